serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1 to 32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operands and borrow-in are valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 b_in  input  1  borrow-in.
REQ-009 out_valid  output  1  diff and b_out are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  difference.
REQ-012 b_out  output  1  borrow-out.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 Handshake: acceptance occurs on an edge where in_valid && in_ready.
  - On acceptance: latch a and b into shift registers, load the borrow register with b_in, clear the bit counter, and go to SHIFT.
REQ-017 Each SHIFT edge processes one bit, LSB first:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the result register MSB-side; the operand registers shift right.
REQ-018 After exactly WIDTH SHIFT edges, the FSM SHALL enter DONE, assert out_valid and drive b_out from the borrow register.
  - out_valid is first visible WIDTH+1 cycles after the acceptance cycle.
REQ-019 Result rules:
  - diff = (a - b - b_in) mod 2^WIDTH.
  - b_out = 1 iff a < b + b_in, evaluated as unsigned with WIDTH+1 bits.
REQ-020 In DONE:
  - diff, b_out and out_valid SHALL hold stable while out_ready = 0.
  - An edge with out_ready = 1 returns the FSM to IDLE and deasserts out_valid.
REQ-021 No new acceptance in the cycle the result is consumed; in_ready first rises in IDLE on the following cycle.
REQ-022 in_valid, a, b and b_in SHALL be ignored in SHIFT and DONE; latched operands are unaffected by input changes after acceptance.
REQ-023 WIDTH = 1 SHALL take exactly one SHIFT edge, with no counter wrap or overrun.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never wrap during an operation.

Reset
REQ-025 When rst = 1 at an edge:
  - State goes to IDLE.
  - out_valid = 0, busy = 0, in_ready = 1 after the edge.
  - diff = 0, b_out = 0, counter and borrow register cleared.
REQ-026 Reset in SHIFT or DONE SHALL discard the operation without emitting out_valid.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-029 The per-bit difference/borrow logic SHALL be a separate combinational sub-module full_subtractor.
  - Ports: x, y, b_in, diff, b_out.
  - Instantiated once and reused every SHIFT cycle.

Verification (WIDTH = 8)
REQ-030 Basic subtract: a = 0x35, b = 0x12, b_in = 0 -> diff = 0x23, b_out = 0, with out_valid exactly 9 cycles after acceptance.
REQ-031 Underflow: a = 0x00, b = 0x01, b_in = 0 -> diff = 0xFF, b_out = 1; borrow-in case a = 0x10, b = 0x0F, b_in = 1 -> diff = 0x00, b_out = 0.
REQ-032 Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> diff/b_out unchanged, in_ready = 0 throughout; out_ready = 1 -> IDLE next cycle.
REQ-033 Reset mid-SHIFT: assert rst on the 4th SHIFT cycle -> no out_valid; busy = 0 and in_ready = 1 after the edge; a following 0xFF - 0xFF yields 0x00, b_out = 0.
REQ-034 Busy ignore: pulse in_valid with a = 0xAA during SHIFT of 0x35 - 0x12 -> result still 0x23; no second result emitted.
REQ-035 Random: 1000 back-to-back operations with random out_ready, checked against the REQ-019 reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - b_in, producing a difference bit and a borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, b_in, then walks the operands LSB first through a
// single full subtractor, one bit per clock, and presents diff/b_out until consumed.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             busy
);

  // Counter must hold WIDTH itself after the last increment, so it never wraps.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             b_out_q, b_out_d;
  logic             bit_diff, bit_borrow;

  full_subtractor u_fs (
    .x     (a_q[0]),
    .y     (b_q[0]),
    .b_in  (br_q),
    .diff  (bit_diff),
    .b_out (bit_borrow)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    b_out_d     = b_out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          br_d       = b_in;
          cnt_d      = '0;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = bit_diff;
        br_d             = bit_borrow;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          b_out_d     = bit_borrow;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      b_out_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      b_out_q     <= b_out_d;
    end
  end

  // Operand shift registers are pure data; a stale value is harmless once IDLE.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = res_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH = 8): directed cases with literal results plus a
// randomized run scored against an arithmetic model of a - b - b_in.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         busy;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   waiting  = 1'b0;
  exp_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    int   x, y, z;
    exp_t e;
    x    = int'(ai);
    y    = int'(bi);
    z    = int'(ci);
    e.d  = W'((x - y - z) & ((1 << W) - 1));
    e.bo = (x < y + z);
    return e;
  endfunction

  // Scoreboard: sees every cycle on the falling edge, when inputs and outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      expq.delete();
      waiting = 1'b0;
    end else begin
      chk("busy_vs_ready", 32'(busy), 32'(!in_ready));
      if (out_valid) begin
        chk("ready_in_done", 32'(in_ready), 32'd0);
        if (expq.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("sb_diff", 32'(diff), 32'(expq[0].d));
          chk("sb_b_out", 32'(b_out), 32'(expq[0].bo));
          if (waiting) begin
            chk("latency", 32'(cyc - acc_cyc), 32'(W + 1));
            waiting = 1'b0;
          end
          if (out_ready) begin
            void'(expq.pop_front());
            n_done++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, b_in);
        expq.push_back(e);
        acc_cyc = cyc;
        waiting = 1'b1;
      end
      if (waiting && (cyc - acc_cyc > W + 1)) begin
        chk("result_timeout", 32'(cyc - acc_cyc), 32'(W + 1));
        waiting = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input logic [W-1:0] ed, input logic eb, input int hold, input bit poke,
                       input string nm);
    bit got = 1'b0;
    in_valid = 1'b1;
    a = ai;
    b = bi;
    b_in = ci;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    chk({nm, "_accepted"}, 32'(got), 32'd1);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    b_in = 1'($urandom);
    if (poke) begin
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      a = 8'hAA;
      b = 8'h01;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_b_out"}, 32'(b_out), 32'(eb));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_diff"}, 32'(diff), 32'(ed));
      chk({nm, "_hold_b_out"}, 32'(b_out), 32'(eb));
      chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_consumed_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    rst = 1'b0;

    do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, 1'b0, "underflow");
    do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 0, 1'b0, "borrow_in");
    do_op(8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 0, 1'b0, "eq_borrow");
    do_op(8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 5, 1'b0, "backpressure");

    // Reset lands on the edge closing the fourth SHIFT cycle.
    in_valid = 1'b1;
    a = 8'h5A;
    b = 8'h21;
    b_in = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    do_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 1'b0, "after_rst");

    do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0, 1'b1, "busy_ignore");
    repeat (15) begin @(posedge clk); #1; end
    chk("busy_ignore_no_second", 32'(out_valid), 32'd0);

    base = n_done;
    guard = 0;
    while ((n_done - base) < 1000 && guard < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      b_in      = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    chk("random_completed", 32'((n_done - base) >= 1000), 32'd1);
    chk("random_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
